// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared definitions for the memory responder and the
//               multicycle controller that drives it: FSM state encodings,
//               default parameter values and the request address check.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    // Default parameter values used by the responder, its bus interface and
    // the controller side.
    localparam int c_DEF_DATA_W  = 32;
    localparam int c_DEF_ADDR_W  = 8;
    localparam int c_DEF_LATENCY = 2;

    // Width of the wait counter; LATENCY must fit in it (0..15).
    localparam int c_CNT_W = 4;

    // Responder FSM state encodings.
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_WAIT   = 2'd1;
    localparam state_t c_ST_ACCESS = 2'd2;
    localparam state_t c_ST_RESP   = 2'd3;

    // A byte address is rejected when it is not word aligned or when any bit
    // above the word index is set (outside the 2**addr_w word array).
    function automatic logic addr_is_bad(input logic [31:0] addr, input int addr_w);
        logic [31:0] w_hi;
        w_hi = addr >> (addr_w + 2);
        return (addr[1:0] != 2'b00) || (w_hi != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Request/response bus between a controller (master) and the
//               memory responder (slave).
//               req/we/addr/wdata : request, sampled by the slave in IDLE
//               ready             : one-cycle response strobe
//               rdata/err         : response payload, valid with ready
//               busy              : slave is not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W
);
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata, err, busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Word-addressed storage with one synchronous write port and
//               one synchronous (registered) read port. No reset: contents
//               survive a responder reset.
//               clk        : rising-edge clock
//               i_wr_en    : write strobe
//               i_wr_addr  : write word address
//               i_wr_data  : write data
//               i_rd_en    : read strobe; o_rd_data updates on the next edge
//               i_rd_addr  : read word address
//               o_rd_data  : read data, held until the next read
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ADDR_W = c_DEF_ADDR_W
)(
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Multicycle memory responder. Accepts one request at a time in
//               IDLE, inserts LATENCY wait cycles, performs a single-cycle
//               array access and returns a one-cycle ready strobe with
//               rdata/err. Bad addresses are answered immediately with err.
//               clk   : rising-edge clock
//               reset : synchronous, active-high reset
//               bus   : slave side of mem_responder_if
//                       (req/we/addr/wdata in, ready/rdata/err/busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter int LATENCY = c_DEF_LATENCY
)(
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam logic [c_CNT_W-1:0] c_LAT = c_CNT_W'(LATENCY);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_word;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_err;
    // Selects the array read register onto rdata. Cleared for write/error
    // responses and on reset so rdata reads 0 there, while the array's own
    // read register (which has no reset) keeps the last read value.
    logic                r_rd_sel;

    logic                w_accept;
    logic                w_addr_bad;
    logic                w_in_access;
    logic                w_wr_en;
    logic                w_rd_en;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_accept    = (r_state == c_ST_IDLE) && bus.req;
    assign w_addr_bad  = addr_is_bad(bus.addr, ADDR_W);
    assign w_in_access = (r_state == c_ST_ACCESS);

    // A reset landing on the ACCESS cycle must not disturb the array.
    assign w_wr_en = w_in_access &&  r_we && !reset;
    assign w_rd_en = w_in_access && !r_we && !reset;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.req) begin
                    if (w_addr_bad) begin
                        w_state_nxt = c_ST_RESP;
                    end else if (c_LAT != '0) begin
                        w_state_nxt = c_ST_WAIT;
                    end else begin
                        w_state_nxt = c_ST_ACCESS;
                    end
                end
            end
            c_ST_WAIT: begin
                // Counter was loaded with LATENCY; leave on the cycle it
                // holds 1 so exactly LATENCY wait cycles are spent here.
                if (r_cnt <= c_CNT_W'(1)) begin
                    w_state_nxt = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: w_state_nxt = c_ST_RESP;
            c_ST_RESP:   w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, wait counter and response payload registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_word   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_rd_sel <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.we;
                r_word  <= bus.addr[ADDR_W+1:2];
                r_wdata <= bus.wdata;
                r_cnt   <= c_LAT;
                // Error responses go straight to RESP, so the payload is
                // updated here rather than in ACCESS.
                if (w_addr_bad) begin
                    r_err    <= 1'b1;
                    r_rd_sel <= 1'b0;
                end
            end
            if (r_state == c_ST_WAIT) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            if (w_in_access) begin
                r_err    <= 1'b0;
                r_rd_sel <= !r_we;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_word),
        .i_wr_data (r_wdata),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_word),
        .o_rd_data (w_rd_data)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ready = (r_state == c_ST_RESP);
    assign bus.busy  = (r_state != c_ST_IDLE);
    assign bus.err   = r_err;
    assign bus.rdata = r_rd_sel ? w_rd_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Instance A runs with
//               LATENCY=2, instance B with LATENCY=0. Expected responses come
//               from a word-array model and the timing rules (bad address ->
//               ready right after acceptance, otherwise LATENCY+1 edges later).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;
    localparam logic [31:0] BYTE_LIMIT = 32'(4 * (2**AW));

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;

    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(DW)) if_a ();
    mem_responder_if #(.DATA_W(DW)) if_b ();

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT_A)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (if_a.slave)
    );

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT_B)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (if_b.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: one word array per instance plus written flags.
    logic [31:0] mdl   [2][256];
    bit          known [2][256];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            if_b.req = req; if_b.we = we; if_b.addr = addr; if_b.wdata = wdata;
        end else begin
            if_a.req = req; if_a.we = we; if_a.addr = addr; if_a.wdata = wdata;
        end
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? if_b.ready : if_a.ready;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? if_b.busy : if_a.busy;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? if_b.err : if_a.err;
    endfunction
    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? if_b.rdata : if_a.rdata;
    endfunction

    // One request from IDLE; expectations derived from the model.
    task automatic op(input bit sel, input string tag, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata);
        bit          bad;
        int          word;
        int          lat;
        int          exp_edges;
        logic [31:0] exp_rd;
        int          edges;
        bit          got;
        logic [31:0] rd;
        logic        er;

        bad       = (addr % 4 != 0) || (addr >= BYTE_LIMIT);
        word      = bad ? 0 : int'(addr / 4);
        lat       = sel ? LAT_B : LAT_A;
        exp_edges = bad ? 0 : lat + 1;
        exp_rd    = (bad || we) ? 32'd0 : mdl[sel][word];

        @(negedge clk);
        drive(sel, 1'b1, we, addr, wdata);
        @(posedge clk);
        #1 drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);

        got = 1'b0; edges = 0; rd = '0; er = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) check({tag, "_busy"}, 64'(get_busy(sel)), 64'd1);
            if (get_ready(sel)) begin
                got = 1'b1; rd = get_rdata(sel); er = get_err(sel);
                break;
            end
            @(posedge clk);
            edges++;
        end
        check({tag, "_got_ready"}, 64'(got), 64'd1);
        check({tag, "_latency"},   64'(edges), 64'(exp_edges));
        check({tag, "_rdata"},     64'(rd), 64'(exp_rd));
        check({tag, "_err"},       64'(er), 64'(bad));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ready_1cyc"}, 64'(get_ready(sel)), 64'd0);
        check({tag, "_idle"},       64'(get_busy(sel)), 64'd0);
        check({tag, "_err_hold"},   64'(get_err(sel)), 64'(bad));

        if (!bad && we) begin
            mdl[sel][word]   = wdata;
            known[sel][word] = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        int          n;
        int          prev;
        int          first_c;

        for (int i = 0; i < 256; i++) begin
            known[0][i] = 1'b0; known[1][i] = 1'b0;
            mdl[0][i] = '0; mdl[1][i] = '0;
        end

        // ---------------- reset, with req asserted (reset wins) ----------
        reset_a = 1'b1; reset_b = 1'b1;
        drive(0, 1'b1, 1'b1, 32'h10, 32'h1111_1111);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(if_a.ready), 64'd0);
        check("rst_busy",  64'(if_a.busy),  64'd0);
        check("rst_err",   64'(if_a.err),   64'd0);
        check("rst_rdata", 64'(if_a.rdata), 64'd0);
        check("rst_b_busy", 64'(if_b.busy), 64'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset_a = 1'b0; reset_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", 64'(if_a.busy), 64'd0);

        // ---------------- directed: write/read, LATENCY=2 ----------------
        op(0, "wr_10", 1'b1, 32'h10, 32'hDEAD_BEEF);
        op(0, "rd_10", 1'b0, 32'h10, 32'h0);

        // ---------------- directed: LATENCY=0 ----------------------------
        op(1, "b_wr_0c", 1'b1, 32'h0C, 32'h1234_5678);
        op(1, "b_rd_0c", 1'b0, 32'h0C, 32'h0);
        op(1, "b_misal", 1'b0, 32'h2, 32'h0);

        // ---------------- error responses, array untouched ---------------
        op(0, "wr_00",    1'b1, 32'h0,   32'h0A0A_0A0A);
        op(0, "rd_misal", 1'b0, 32'h2,   32'h0);
        op(0, "rd_oor",   1'b0, 32'h400, 32'h0);
        op(0, "wr_oor",   1'b1, 32'h400, 32'hBAD0_BAD0);
        op(0, "wr_hi",    1'b1, 32'h8000_0010, 32'hBAD1_BAD1);
        op(0, "rd_00_chk", 1'b0, 32'h0,  32'h0);
        op(0, "rd_10_chk", 1'b0, 32'h10, 32'h0);

        // ---------------- randomized traffic ------------------------------
        for (int i = 0; i < 32; i++) begin
            op(0, "fill", 1'b1, 32'(i * 4), $urandom);
        end
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 31) * 4);
            d = $urandom;
            case ($urandom_range(0, 7))
                0: a = a | 32'($urandom_range(1, 3));
                1: a = a | (32'($urandom_range(1, 4095)) << 10);
                default: ;
            endcase
            op(0, "rand", w, a, d);
        end

        // ---------------- req held for three requests --------------------
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        n = 0; prev = -1;
        for (int c = 0; c < 3 * (LAT_A + 3); c++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_a.ready) begin
                if (n > 0) check("held_gap", 64'(c - prev), 64'(LAT_A + 3));
                else       check("held_first", 64'(c), 64'(LAT_A + 1));
                check("held_rdata", 64'(if_a.rdata), 64'(mdl[0][4]));
                prev = c;
                n++;
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("held_count", 64'(n), 64'd3);
        @(posedge clk);
        @(negedge clk);
        check("held_no_extra", 64'(if_a.busy), 64'd0);

        // ---------------- reset during WAIT abandons write ---------------
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, ~mdl[0][8]);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("rstw_in_wait", 64'(if_a.busy), 64'd1);
        reset_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstw_busy",  64'(if_a.busy),  64'd0);
        check("rstw_rdata", 64'(if_a.rdata), 64'd0);
        reset_a = 1'b0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_a.ready) n++;
        end
        check("rstw_no_ready", 64'(n), 64'd0);
        op(0, "rstw_rd_20", 1'b0, 32'h20, 32'h0);

        // ---------------- reset coincident with ACCESS -------------------
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h24, ~mdl[0][9]);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (LAT_A) @(posedge clk);
        @(negedge clk);
        reset_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rsta_ready", 64'(if_a.ready), 64'd0);
        reset_a = 1'b0;
        op(0, "rsta_rd_24", 1'b0, 32'h24, 32'h0);

        // ---------------- req pulsed while busy is ignored ---------------
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h14, 32'h0);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h18, ~mdl[0][6]);
        n = 0; first_c = -1;
        for (int c = 1; c <= 2 * (LAT_A + 3); c++) begin
            @(posedge clk);
            #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            if (if_a.ready) begin
                if (n == 0) begin
                    first_c = c;
                    check("busy_rdata", 64'(if_a.rdata), 64'(mdl[0][5]));
                end
                n++;
            end
        end
        check("busy_ready_cnt", 64'(n), 64'd1);
        check("busy_ready_at", 64'(first_c), 64'(LAT_A + 1));
        op(0, "busy_rd_18", 1'b0, 32'h18, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DATA_W, default 32, data word width in bits.
REQ-002 Parameter: ADDR_W, default 8, word-address bits (256 words).
REQ-003 Parameter: LATENCY, default 2, wait cycles inserted before each array access (0..15).
REQ-004 Clock is `clk` and reset is `reset`; one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  1  access request from the controller, sampled only in IDLE.
REQ-008 we  input  1  1 = write, 0 = read; sampled with req.
REQ-009 addr  input  32  byte address; sampled with req.
REQ-010 wdata  input  DATA_W  write data; sampled with req.
REQ-011 ready  output  1  one-cycle response strobe.
REQ-012 rdata  output  DATA_W  read data; valid while ready = 1.
REQ-013 err  output  1  error flag; valid while ready = 1.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States: IDLE, WAIT, ACCESS, RESP.
REQ-016 In IDLE with req = 1, the block shall register we, addr and wdata and load the wait counter with LATENCY.
REQ-017 From IDLE, a request shall go to RESP with pending error if addr[1:0] != 0 or addr[31:ADDR_W+2] != 0.
REQ-018 Otherwise, from IDLE a request shall go to WAIT if LATENCY > 0, else to ACCESS.
REQ-019 WAIT shall decrement the counter each cycle and go to ACCESS in the cycle the counter reaches 1.
REQ-020 ACCESS shall last one cycle.
REQ-021 In ACCESS, a write shall store the registered wdata at word addr[ADDR_W+1:2].
REQ-022 In ACCESS, a read shall register array data into rdata.
REQ-023 ACCESS shall then go to RESP.
REQ-024 RESP shall assert ready for exactly one cycle and then go to IDLE.
REQ-025 Latency: a request accepted at edge N shall produce ready in the cycle after edge N+LATENCY+1 (ready visible for cycles N+LATENCY+2).
REQ-026 An error response shall assert ready one cycle after acceptance, with no array access.
REQ-027 err shall be 1 only in an error response; rdata shall be 0 for write and error responses.
REQ-028 rdata and err shall hold their last values outside RESP.
REQ-029 req while busy = 1 shall be ignored and not queued; the controller re-asserts it after ready.
REQ-030 req asserted in the same cycle as ready (RESP) shall be ignored; it is accepted on the next IDLE cycle.
REQ-031 Back-to-back requests shall have a minimum spacing of LATENCY+3 cycles.

Reset
REQ-032 While reset = 1: state = IDLE, ready = 0, err = 0, rdata = 0, busy = 0, counter = 0.
REQ-033 Reset takes priority over req.
REQ-034 Reset asserted in IDLE or WAIT shall abandon the pending access with no array write.
REQ-035 Reset coincident with ACCESS shall suppress the write.
REQ-036 Array contents are not cleared by reset.

Structure
REQ-037 State encodings and the default parameter values shall live in a shared package shared with the multicycle controller.
REQ-038 The storage array shall be a sub-module, mem_array: one synchronous write port and one synchronous read port, no reset.

Verification
REQ-039 LATENCY=2: write addr 0x10, wdata 0xDEADBEEF -> ready with err=0, rdata=0 at cycle N+4; then read 0x10 -> rdata=0xDEADBEEF, err=0.
REQ-040 LATENCY=0: read of word 3 (addr 0x0C) preloaded with 0x12345678 -> ready at N+2, rdata=0x12345678.
REQ-041 Read addr 0x0000_0002 (misaligned), and separately addr 0x0000_0400 (out of range) -> ready at N+1, err=1, rdata=0; array unchanged.
REQ-042 req held high continuously for 3 requests -> each response separated by LATENCY+3 cycles; no duplicate or dropped responses.
REQ-043 Write to 0x20 with reset asserted during WAIT -> no ready; a subsequent read of 0x20 returns the prior contents.
REQ-044 req pulsed while busy -> no extra ready, and the state sequence is unaffected.
